// File: rtl/prefetch_fifo_sc_if.sv
// rtl/prefetch_fifo_sc_if.sv - user-side bus of the single-clock prefetch FIFO
//
// Purpose : groups the flush, write, read and status signals of prefetch_fifo_sc
//           so producer/consumer logic and the FIFO connect through one port.
// Signals : flush                          synchronous clear
//           wr_en / wr_vld / wr_data       write request, not-full, write word
//           rd_en / rd_vld / rd_data       pop request, head valid, head word
//           count                          words held, 0..2**DEPTH_WIDTH
//           almost_full / almost_empty     programmable threshold flags
//           overflow / underflow           sticky error flags, only with
//                                          PREFETCH_FIFO_ERR_FLAG_EN defined
// Modports: master = producer/consumer side, slave = FIFO side.
interface prefetch_fifo_sc_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH_WIDTH = 10
);
  logic                   flush;
  logic                   wr_en;
  logic                   wr_vld;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   rd_en;
  logic                   rd_vld;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic [DEPTH_WIDTH:0]   count;
  logic                   almost_full;
  logic                   almost_empty;
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
  logic                   overflow;
  logic                   underflow;
`endif

  modport master (
    output flush, wr_en, wr_data, rd_en,
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
    input  overflow, underflow,
`endif
    input  wr_vld, rd_vld, rd_data, count, almost_full, almost_empty
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
    output overflow, underflow,
`endif
    output wr_vld, rd_vld, rd_data, count, almost_full, almost_empty
  );
endinterface

// File: rtl/prefetch_fifo_sc.sv
// rtl/prefetch_fifo_sc.sv - single-clock first-word-fall-through FIFO with occupancy and flags
//
// Purpose : parametrised prefetch FIFO. Storage is a simple dual-port RAM with
//           a synchronous read; the head word is presented from a dedicated
//           output register (rd_data) qualified by rd_vld.
// Ports   : clk    - single clock, rising edge
//           rst_n  - asynchronous active-low reset, synchronous release
//           bus    - prefetch_fifo_sc_if.slave (flush, write, read, status)
// Options : PREFETCH_FIFO_ERR_FLAG_EN adds sticky overflow/underflow flags.
module prefetch_fifo_sc #(
  parameter int DATA_WIDTH      = 12,
  parameter int DEPTH_WIDTH     = 10,
  parameter int ALMOST_FULL_TH  = 2**DEPTH_WIDTH - 4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  prefetch_fifo_sc_if.slave bus
);

  localparam int               CNT_W   = DEPTH_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] AF_TH_C = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] AE_TH_C = CNT_W'(ALMOST_EMPTY_TH);

  // Output stage states; bit 1 doubles as rd_vld so that flag is a flop output.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_VALID = 2'b10;

  logic [DATA_WIDTH-1:0]  mem [0:(2**DEPTH_WIDTH)-1];
  logic [DATA_WIDTH-1:0]  ram_q;

  logic [1:0]             state_q,   state_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [DEPTH_WIDTH-1:0] wptr_q,    wptr_d;
  logic [DEPTH_WIDTH-1:0] rptr_q,    rptr_d;
  logic [CNT_W-1:0]       ram_cnt_q, ram_cnt_d;
  logic [CNT_W-1:0]       count_q,   count_d;
  logic                   wr_vld_q,  wr_vld_d;
  logic                   af_q,      af_d;
  logic                   ae_q,      ae_d;

  logic                   rd_vld;
  logic                   ram_empty;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   ram_take;
  logic [DEPTH_WIDTH-1:0] rd_addr;

  // ram_cnt counts words still in the RAM; the word in the output register is
  // no longer counted there, so count == ram_cnt + rd_vld at all times.
  always_comb begin
    rd_vld    = state_q[1];
    ram_empty = (ram_cnt_q == '0);
    wr_acc    = bus.wr_en & wr_vld_q & ~bus.flush;
    rd_acc    = bus.rd_en & rd_vld & ~bus.flush;
    // ram_take moves the RAM head into the output register: on LOAD->VALID,
    // or on a pop while the RAM still holds a successor (no bubble).
    ram_take  = ~bus.flush & ((state_q == ST_LOAD) | (rd_acc & ~ram_empty));
    // Address the successor one edge ahead so ram_q always holds mem[rptr].
    rd_addr   = ram_take ? rptr_q + DEPTH_WIDTH'(1) : rptr_q;

    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (!ram_empty)          state_d = ST_LOAD;
      ST_LOAD:                           state_d = ST_VALID;
      ST_VALID: if (rd_acc && ram_empty) state_d = ST_EMPTY;
      default:                           state_d = ST_EMPTY;
    endcase

    rd_data_d = ram_take ? ram_q : rd_data_q;
    wptr_d    = wr_acc ? wptr_q + DEPTH_WIDTH'(1) : wptr_q;
    rptr_d    = rd_addr;

    ram_cnt_d = ram_cnt_q;
    case ({wr_acc, ram_take})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      state_d   = ST_EMPTY;
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      count_d   = '0;
    end

    // Status flags are registered from the next count so they move with it.
    wr_vld_d = (count_d < DEPTH_C);
    af_d     = (count_d >= AF_TH_C);
    ae_d     = (count_d <= AE_TH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      rd_data_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      wr_vld_q  <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      wr_vld_q  <= wr_vld_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  // Block RAM with read-first synchronous read. A write to the very address
  // being read can only be the next head (RAM otherwise empty at that slot),
  // so it is forwarded into ram_q to keep the no-bubble pop correct.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_q] <= bus.wr_data;
    end
    if (wr_acc && (wptr_q == rd_addr)) begin
      ram_q <= bus.wr_data;
    end else begin
      ram_q <= mem[rd_addr];
    end
  end

  assign bus.wr_vld       = wr_vld_q;
  assign bus.rd_vld       = rd_vld;
  assign bus.rd_data      = rd_data_q;
  assign bus.count        = count_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;

`ifdef PREFETCH_FIFO_ERR_FLAG_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en & ~wr_vld_q);
    underflow_d = underflow_q | (bus.rd_en & ~rd_vld);
    if (bus.flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_prefetch_fifo_sc.sv
// tb/tb_prefetch_fifo_sc.sv - directed self-checking bench for prefetch_fifo_sc
module tb_prefetch_fifo_sc;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  prefetch_fifo_sc_if #(.DATA_WIDTH(12), .DEPTH_WIDTH(4)) bus ();

  prefetch_fifo_sc #(
    .DATA_WIDTH     (12),
    .DEPTH_WIDTH    (4),
    .ALMOST_FULL_TH (12),
    .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [11:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_rd_vld",  32'(bus.rd_vld), 0);
    check_eq("rst_rd_data", 32'(bus.rd_data), 0);
    check_eq("rst_count",   32'(bus.count), 0);
    check_eq("rst_ae",      32'(bus.almost_empty), 1);
    check_eq("rst_af",      32'(bus.almost_full), 0);
    check_eq("rst_wr_vld",  32'(bus.wr_vld), 0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_wr_vld",  32'(bus.wr_vld), 1);

    // Single write into empty FIFO: two-edge latency, then held stable
    write_word(12'h0A5);
    check_eq("s1_count_n",  32'(bus.count), 1);
    check_eq("s1_vld_n",    32'(bus.rd_vld), 0);
    tick();
    check_eq("s1_vld_n1",   32'(bus.rd_vld), 0);
    tick();
    check_eq("s1_vld_n2",   32'(bus.rd_vld), 1);
    check_eq("s1_data_n2",  32'(bus.rd_data), 32'h0A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("s1_hold_vld",  32'(bus.rd_vld), 1);
      check_eq("s1_hold_data", 32'(bus.rd_data), 32'h0A5);
    end
    check_eq("s1_ae", 32'(bus.almost_empty), 1);
    // Write into the slot just behind the head, then pop on the next cycle
    write_word(12'h05A);
    check_eq("s1_count2", 32'(bus.count), 2);
    bus.rd_en = 1'b1;
    tick();
    check_eq("s1_pop_vld",  32'(bus.rd_vld), 1);
    check_eq("s1_pop_data", 32'(bus.rd_data), 32'h05A);
    tick();
    bus.rd_en = 1'b0;
    check_eq("s1_empty_vld",   32'(bus.rd_vld), 0);
    check_eq("s1_empty_count", 32'(bus.count), 0);

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) begin
      write_word(12'(i));
      check_eq("s2_count",  32'(bus.count), 32'(i + 1));
      check_eq("s2_af",     32'(bus.almost_full), 32'((i + 1) >= 12));
      check_eq("s2_ae",     32'(bus.almost_empty), 32'((i + 1) <= 2));
      check_eq("s2_wr_vld", 32'(bus.wr_vld), 32'((i + 1) < 16));
    end
    write_word(12'h3FF);
    check_eq("s2_ovf_count", 32'(bus.count), 16);
    check_eq("s2_ovf_wrvld", 32'(bus.wr_vld), 0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("s2_rd_vld",  32'(bus.rd_vld), 1);
      check_eq("s2_rd_data", 32'(bus.rd_data), 32'(i));
      tick();
    end
    bus.rd_en = 1'b0;
    check_eq("s2_end_vld",   32'(bus.rd_vld), 0);
    check_eq("s2_end_count", 32'(bus.count), 0);

    // Full FIFO: simultaneous write and read, write dropped
    for (int i = 0; i < 16; i++) write_word(12'h100 + 12'(i));
    check_eq("s3_full_wrvld", 32'(bus.wr_vld), 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 12'h1AA;
    bus.rd_en   = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("s3_count",  32'(bus.count), 15);
    check_eq("s3_wr_vld", 32'(bus.wr_vld), 1);
    check_eq("s3_head",   32'(bus.rd_data), 32'h101);
    write_word(12'h1BB);
    check_eq("s3_refill", 32'(bus.count), 16);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("s3_rd_vld",  32'(bus.rd_vld), 1);
      check_eq("s3_rd_data", 32'(bus.rd_data), (i < 15) ? 32'(12'h101 + 12'(i)) : 32'h1BB);
      tick();
    end
    bus.rd_en = 1'b0;
    check_eq("s3_end_count", 32'(bus.count), 0);

    // Streaming after a 3-word prefill, across several pointer wraps
    for (int i = 0; i < 3; i++) write_word(12'h200 + 12'(i));
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    for (int j = 0; j < 100; j++) begin
      bus.wr_data = 12'h200 + 12'(j + 3);
      check_eq("s4_rd_vld",  32'(bus.rd_vld), 1);
      check_eq("s4_rd_data", 32'(bus.rd_data), 32'(12'h200 + 12'(j)));
      tick();
      check_eq("s4_count",   32'(bus.count), 3);
    end
    bus.wr_en = 1'b0;
    for (int j = 100; j < 103; j++) begin
      check_eq("s4_tail_data", 32'(bus.rd_data), 32'(12'h200 + 12'(j)));
      tick();
    end
    bus.rd_en = 1'b0;
    check_eq("s4_end_count", 32'(bus.count), 0);

    // Flush with count=9 while writing
    for (int i = 0; i < 9; i++) write_word(12'h300 + 12'(i));
    tick();
    check_eq("s5_pre_count", 32'(bus.count), 9);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 12'h0EE;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    check_eq("s5_count",  32'(bus.count), 0);
    check_eq("s5_rd_vld", 32'(bus.rd_vld), 0);
    check_eq("s5_ae",     32'(bus.almost_empty), 1);
    check_eq("s5_af",     32'(bus.almost_full), 0);
    check_eq("s5_wr_vld", 32'(bus.wr_vld), 1);
    tick();
    tick();
    check_eq("s5_absent_vld",   32'(bus.rd_vld), 0);
    check_eq("s5_absent_count", 32'(bus.count), 0);
    // Write with a read while empty: write accepted, read ignored
    bus.rd_en = 1'b1;
    write_word(12'h123);
    bus.rd_en = 1'b0;
    check_eq("s5_w_count", 32'(bus.count), 1);
    tick();
    check_eq("s5_w_vld1",  32'(bus.rd_vld), 0);
    tick();
    check_eq("s5_w_vld2",  32'(bus.rd_vld), 1);
    check_eq("s5_w_data",  32'(bus.rd_data), 32'h123);

    // Reset mid-operation discards contents immediately
    write_word(12'h456);
    tick();
    tick();
    check_eq("mr_pre_count", 32'(bus.count), 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_count",  32'(bus.count), 0);
    check_eq("mr_rd_vld", 32'(bus.rd_vld), 0);
    check_eq("mr_wr_vld", 32'(bus.wr_vld), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mr_rel_wrvld", 32'(bus.wr_vld), 1);
    tick();
    tick();
    check_eq("mr_post_vld", 32'(bus.rd_vld), 0);

`ifdef PREFETCH_FIFO_ERR_FLAG_EN
    // Sticky error flags
    check_eq("ef_ovf_init", 32'(bus.overflow), 0);
    check_eq("ef_udf_init", 32'(bus.underflow), 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("ef_udf_set", 32'(bus.underflow), 1);
    tick();
    check_eq("ef_udf_sticky", 32'(bus.underflow), 1);
    check_eq("ef_ovf_clean",  32'(bus.overflow), 0);
    for (int i = 0; i < 16; i++) write_word(12'(i));
    check_eq("ef_ovf_full", 32'(bus.overflow), 0);
    write_word(12'h777);
    check_eq("ef_ovf_set", 32'(bus.overflow), 1);
    tick();
    check_eq("ef_ovf_sticky", 32'(bus.overflow), 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("ef_ovf_flush", 32'(bus.overflow), 0);
    check_eq("ef_udf_flush", 32'(bus.underflow), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
